jtframe_dump_trig: RTL and testbench
====================================

// Module: jtframe_dump_trig
// PURPOSE
//  Generates the frame count and waveform-dump window for simulation and debug
//  capture. Counts falling edges of vertical sync, gates counting on the ROM
//  download signal and opens/closes a dump window on programmed frames. The
//  dump helper and SDRAM statistics logic consume its outputs.
// PARAMETERS
//  CNTW     32  width of frame_cnt
//  WAIT_DL  0   1: stay idle until downloading falls; 0: armed right after reset
//  START    0   frame_cnt value (pre-increment) at which the window opens
//  STOP     0   frame_cnt value at which the window closes; 0 or <=START = never
// PORTS
//  clk          in   1     system clock
//  rst          in   1     asynchronous reset, active high
//  vs           in   1     vertical sync, synchronous to clk, active low
//  downloading  in   1     ROM download in progress (led)
//  frame_cnt    out  CNTW  frames since last reset/download end
//  vs_fall      out  1     one-cycle pulse per vs falling edge
//  dump_en      out  1     dump window open
//  dump_start   out  1     one-cycle pulse when window opens
//  dump_stop    out  1     one-cycle pulse when window closes or aborts
//  st           out  2     FSM state: 0 WAIT_DL, 1 ARMED, 2 DUMPING, 3 DONE
// BEHAVIOUR
//  Reset (async, rst=1): frame_cnt=0, vs_fall=0, dump_en=0, dump_start=0,
//   dump_stop=0, vs_l=1, dl_l=0; st=WAIT_DL if WAIT_DL=1 else ARMED.
//  Edge detect: vs_l<=vs, dl_l<=downloading each cycle.
//   fall = vs_l & ~vs ; dl_end = dl_l & ~downloading ; dl_rise = ~dl_l & downloading.
//  All outputs registered; every reaction appears one clk after the input edge.
//  vs_fall<=fall & ~downloading. Pulses high exactly one cycle.
//  frame_cnt: held at 0 while downloading=1; else +1 on fall; wraps 2^CNTW-1 -> 0.
//  Comparisons use frame_cnt value before that edge's increment.
//  FSM (transitions evaluated in priority order):
//   any state, dl_rise: st<=WAIT_DL; if st==DUMPING: dump_en<=0, dump_stop<=1.
//   WAIT_DL: dl_end -> ARMED (frame_cnt already 0). With WAIT_DL=0, also
//    re-enter here on dl_rise and leave on dl_end as above.
//   ARMED: fall & frame_cnt==START -> DUMPING, dump_en<=1, dump_start<=1.
//   DUMPING: fall & stop_ok & frame_cnt==STOP -> DONE, dump_en<=0, dump_stop<=1.
//    stop_ok = (STOP!=0) && (STOP>START), a constant.
//   DONE: holds; leaves only on rst or dl_rise.
//  Simultaneous fall and downloading=1: no count, no vs_fall, no FSM advance.
//  Simultaneous fall and dl_end: dl_end handled; fall ignored (downloading still
//   sampled high on the previous cycle, so vs_fall=0).
//  START==0 with WAIT_DL=0: window opens at the first fall after reset.
//  Wrap: the window can still open after frame_cnt wraps back to START.
//  Reset mid-DUMPING: dump_en drops asynchronously, no dump_stop pulse.
// TESTING
//  T1 WAIT_DL=0,START=3,STOP=6: 10 vs falls -> frame_cnt 0..10; dump_start on
//   the 4th fall; dump_stop on the 7th; dump_en high for 3 frames; st ends 3.
//  T2 WAIT_DL=1,START=0: 5 falls with downloading=0 -> frame_cnt=5, st=0;
//   pulse downloading 1->0 -> st=1; next fall -> dump_start, frame_cnt=1.
//  T3 downloading=1 held over 4 falls -> frame_cnt stays 0, vs_fall never pulses.
//  T4 DUMPING, raise downloading -> next clk dump_en=0, dump_stop=1, st=0,
//   frame_cnt=0; lower it and reach START again -> window reopens.
//  T5 CNTW=4,START=2,STOP=0: 20 falls -> frame_cnt wraps 15->0; dump_start
//   once only; dump_en never falls.
//  T6 assert rst during DUMPING -> dump_en, frame_cnt 0 same cycle; st=ARMED.

Source files
------------

// File: rtl/jtframe_dump_trig.sv
// Frame counter and waveform-dump window generator driven by vertical sync.
// Latency: every output is registered and reacts one clk after the input edge.
// Backpressure: none; free-running observer of vs/downloading.
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   vs                  vertical sync (active low, synchronous to clk)
//   downloading         ROM download in progress; holds the counter at zero
//   frame_cnt           frames counted since reset or download end
//   vs_fall             one-cycle pulse per accepted vs falling edge
//   dump_en             dump window open
//   dump_start/stop     one-cycle pulses when the window opens / closes
//   st                  FSM state: 0 WAIT_DL, 1 ARMED, 2 DUMPING, 3 DONE
module jtframe_dump_trig #(
  parameter int CNTW    = 32,
  parameter int WAIT_DL = 0,
  parameter int START   = 0,
  parameter int STOP    = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            vs,
  input  logic            downloading,
  output logic [CNTW-1:0] frame_cnt,
  output logic            vs_fall,
  output logic            dump_en,
  output logic            dump_start,
  output logic            dump_stop,
  output logic [1:0]      st
);

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_DUMPING = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam state_t          RST_ST  = (WAIT_DL != 0) ? ST_WAIT : ST_ARMED;
  localparam logic [CNTW-1:0] START_V = CNTW'(START);
  localparam logic [CNTW-1:0] STOP_V  = CNTW'(STOP);
  // A STOP of zero, or one not past START, leaves the window open forever.
  localparam bit              STOP_OK = (STOP != 0) && (STOP > START);

  state_t state, state_nxt;
  logic   en_nxt, start_nxt, stop_nxt;
  logic   vs_l, dl_l;
  logic   fall, dl_end, dl_rise, fall_ok;

  assign fall    = vs_l & ~vs;
  assign dl_end  = dl_l & ~downloading;
  assign dl_rise = ~dl_l & downloading;
  // A fall coinciding with the end of a download is dropped: the download
  // was still active on the previous cycle, so the frame is not counted.
  assign fall_ok = fall & ~downloading & ~dl_l;
  assign st      = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_l      <= 1'b1;
      dl_l      <= 1'b0;
      frame_cnt <= '0;
      vs_fall   <= 1'b0;
    end else begin
      vs_l    <= vs;
      dl_l    <= downloading;
      vs_fall <= fall_ok;
      if (downloading)
        frame_cnt <= '0;
      else if (fall_ok)
        frame_cnt <= frame_cnt + CNTW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RST_ST;
      dump_en    <= 1'b0;
      dump_start <= 1'b0;
      dump_stop  <= 1'b0;
    end else begin
      state      <= state_nxt;
      dump_en    <= en_nxt;
      dump_start <= start_nxt;
      dump_stop  <= stop_nxt;
    end
  end

  // Comparisons see frame_cnt before this edge's increment.
  always_comb begin
    state_nxt = state;
    en_nxt    = dump_en;
    start_nxt = 1'b0;
    stop_nxt  = 1'b0;
    if (dl_rise) begin
      state_nxt = ST_WAIT;
      if (state == ST_DUMPING) begin
        en_nxt   = 1'b0;
        stop_nxt = 1'b1;
      end
    end else begin
      case (state)
        ST_WAIT: begin
          if (dl_end) state_nxt = ST_ARMED;
        end
        ST_ARMED: begin
          if (fall_ok && frame_cnt == START_V) begin
            state_nxt = ST_DUMPING;
            en_nxt    = 1'b1;
            start_nxt = 1'b1;
          end
        end
        ST_DUMPING: begin
          if (fall_ok && STOP_OK && frame_cnt == STOP_V) begin
            state_nxt = ST_DONE;
            en_nxt    = 1'b0;
            stop_nxt  = 1'b1;
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_dump_trig.sv
module tb_jtframe_dump_trig;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vs = 1'b1;
  logic dl = 1'b0;
  int   tests = 0;
  int   fails = 0;

  // dut1: WAIT_DL=0 START=3 STOP=6
  logic [31:0] cnt1; logic f1, en1, sa1, so1; logic [1:0] st1;
  // dut2: WAIT_DL=1 START=0 STOP=0
  logic [31:0] cnt2; logic f2, en2, sa2, so2; logic [1:0] st2;
  // dut5: CNTW=4 START=2 STOP=0
  logic [3:0]  cnt5; logic f5, en5, sa5, so5; logic [1:0] st5;

  always #5 clk = ~clk;

  jtframe_dump_trig #(.CNTW(32), .WAIT_DL(0), .START(3), .STOP(6)) dut1 (
    .clk(clk), .rst(rst), .vs(vs), .downloading(dl), .frame_cnt(cnt1),
    .vs_fall(f1), .dump_en(en1), .dump_start(sa1), .dump_stop(so1), .st(st1));
  jtframe_dump_trig #(.CNTW(32), .WAIT_DL(1), .START(0), .STOP(0)) dut2 (
    .clk(clk), .rst(rst), .vs(vs), .downloading(dl), .frame_cnt(cnt2),
    .vs_fall(f2), .dump_en(en2), .dump_start(sa2), .dump_stop(so2), .st(st2));
  jtframe_dump_trig #(.CNTW(4), .WAIT_DL(0), .START(2), .STOP(0)) dut5 (
    .clk(clk), .rst(rst), .vs(vs), .downloading(dl), .frame_cnt(cnt5),
    .vs_fall(f5), .dump_en(en5), .dump_start(sa5), .dump_stop(so5), .st(st5));

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; vs = 1'b1; dl = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Leaves the bench one negedge after the posedge that saw the fall.
  task automatic fall_step();
    vs = 1'b1;
    @(negedge clk);
    vs = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; vs = 1'b1; dl = 1'b0;
    @(negedge clk);
    tests++; if (cnt1 !== 32'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", cnt1); end
    tests++; if ({f1, en1, sa1, so1} !== 4'b0) begin fails++; $display("FAIL reset_outs got %b want 0000", {f1, en1, sa1, so1}); end
    tests++; if (st1 !== 2'd1) begin fails++; $display("FAIL reset_st1 got %0d want 1", st1); end
    tests++; if (st2 !== 2'd0) begin fails++; $display("FAIL reset_st2 got %0d want 0", st2); end
    tests++; if (st5 !== 2'd1) begin fails++; $display("FAIL reset_st5 got %0d want 1", st5); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_window();
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      fall_step();
      tests++; if (cnt1 !== 32'(i)) begin fails++; $display("FAIL t1_cnt fall %0d got %0d want %0d", i, cnt1, i); end
      tests++; if (f1 !== 1'b1) begin fails++; $display("FAIL t1_vsfall fall %0d got %b want 1", i, f1); end
      tests++; if (sa1 !== (i == 4)) begin fails++; $display("FAIL t1_start fall %0d got %b want %b", i, sa1, i == 4); end
      tests++; if (so1 !== (i == 7)) begin fails++; $display("FAIL t1_stop fall %0d got %b want %b", i, so1, i == 7); end
      tests++; if (en1 !== (i >= 4 && i < 7)) begin fails++; $display("FAIL t1_en fall %0d got %b want %b", i, en1, i >= 4 && i < 7); end
      vs = 1'b1;
      @(negedge clk);
      tests++; if (f1 !== 1'b0) begin fails++; $display("FAIL t1_vsfall_width fall %0d got %b want 0", i, f1); end
    end
    tests++; if (st1 !== 2'd3) begin fails++; $display("FAIL t1_st_end got %0d want 3", st1); end
  endtask

  task automatic test_wait_dl();
    do_reset();
    for (int i = 0; i < 5; i++) fall_step();
    tests++; if (cnt2 !== 32'd5) begin fails++; $display("FAIL t2_cnt got %0d want 5", cnt2); end
    tests++; if (st2 !== 2'd0) begin fails++; $display("FAIL t2_st_wait got %0d want 0", st2); end
    tests++; if (en2 !== 1'b0) begin fails++; $display("FAIL t2_en_idle got %b want 0", en2); end
    vs = 1'b1; dl = 1'b1;
    @(negedge clk);
    tests++; if (cnt2 !== 32'd0) begin fails++; $display("FAIL t2_cnt_dl got %0d want 0", cnt2); end
    dl = 1'b0;
    @(negedge clk);
    tests++; if (st2 !== 2'd1) begin fails++; $display("FAIL t2_st_armed got %0d want 1", st2); end
    fall_step();
    tests++; if (sa2 !== 1'b1) begin fails++; $display("FAIL t2_start got %b want 1", sa2); end
    tests++; if (cnt2 !== 32'd1) begin fails++; $display("FAIL t2_cnt_after got %0d want 1", cnt2); end
    tests++; if (st2 !== 2'd2) begin fails++; $display("FAIL t2_st_dump got %0d want 2", st2); end
  endtask

  task automatic test_dl_hold();
    do_reset();
    dl = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      fall_step();
      tests++; if (f1 !== 1'b0) begin fails++; $display("FAIL t3_vsfall fall %0d got %b want 0", i, f1); end
      tests++; if (cnt1 !== 32'd0) begin fails++; $display("FAIL t3_cnt fall %0d got %0d want 0", i, cnt1); end
    end
    vs = 1'b1; dl = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort();
    do_reset();
    for (int i = 0; i < 4; i++) fall_step();
    tests++; if (en1 !== 1'b1) begin fails++; $display("FAIL t4_en_open got %b want 1", en1); end
    vs = 1'b1; dl = 1'b1;
    @(negedge clk);
    tests++; if (en1 !== 1'b0) begin fails++; $display("FAIL t4_en_abort got %b want 0", en1); end
    tests++; if (so1 !== 1'b1) begin fails++; $display("FAIL t4_stop_abort got %b want 1", so1); end
    tests++; if (st1 !== 2'd0) begin fails++; $display("FAIL t4_st_wait got %0d want 0", st1); end
    tests++; if (cnt1 !== 32'd0) begin fails++; $display("FAIL t4_cnt_zero got %0d want 0", cnt1); end
    @(negedge clk);
    tests++; if (so1 !== 1'b0) begin fails++; $display("FAIL t4_stop_width got %b want 0", so1); end
    // vs falls on the same cycle the download ends: that fall is not counted.
    dl = 1'b0; vs = 1'b0;
    @(negedge clk);
    tests++; if (st1 !== 2'd1) begin fails++; $display("FAIL t4_st_armed got %0d want 1", st1); end
    tests++; if (f1 !== 1'b0) begin fails++; $display("FAIL t4_fall_dlend got %b want 0", f1); end
    tests++; if (cnt1 !== 32'd0) begin fails++; $display("FAIL t4_cnt_dlend got %0d want 0", cnt1); end
    for (int i = 1; i <= 4; i++) begin
      fall_step();
      tests++; if (sa1 !== (i == 4)) begin fails++; $display("FAIL t4_reopen fall %0d got %b want %b", i, sa1, i == 4); end
    end
    tests++; if (en1 !== 1'b1) begin fails++; $display("FAIL t4_en_reopen got %b want 1", en1); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      fall_step();
      tests++; if (cnt5 !== 4'(i % 16)) begin fails++; $display("FAIL t5_cnt fall %0d got %0d want %0d", i, cnt5, i % 16); end
      tests++; if (sa5 !== (i == 3)) begin fails++; $display("FAIL t5_start fall %0d got %b want %b", i, sa5, i == 3); end
      tests++; if (en5 !== (i >= 3)) begin fails++; $display("FAIL t5_en fall %0d got %b want %b", i, en5, i >= 3); end
      tests++; if (so5 !== 1'b0) begin fails++; $display("FAIL t5_stop fall %0d got %b want 0", i, so5); end
    end
  endtask

  task automatic test_rst_dumping();
    do_reset();
    for (int i = 0; i < 5; i++) fall_step();
    tests++; if (en1 !== 1'b1) begin fails++; $display("FAIL t6_en_open got %b want 1", en1); end
    rst = 1'b1;
    #1;
    tests++; if (en1 !== 1'b0) begin fails++; $display("FAIL t6_en_async got %b want 0", en1); end
    tests++; if (cnt1 !== 32'd0) begin fails++; $display("FAIL t6_cnt_async got %0d want 0", cnt1); end
    tests++; if (st1 !== 2'd1) begin fails++; $display("FAIL t6_st got %0d want 1", st1); end
    tests++; if (so1 !== 1'b0) begin fails++; $display("FAIL t6_no_stop got %b want 0", so1); end
    @(negedge clk);
    rst = 1'b0; vs = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_window();
    test_wait_dl();
    test_dl_hold();
    test_abort();
    test_wrap();
    test_rst_dumping();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
